mem_responder: RTL and testbench

// - Memory-side responder for the 16-bit pipeline's word-access request port (fetch and TLB/mem stage requests arbitrated upstream).
// - Accepts one read or write request per valid/ready handshake and models main-memory latency with a countdown.
// - Returns the response over a valid/ready channel that supports backpressure.
// - Sits between the pipeline's memory initiator and the backing storage array; one request outstanding at a time.

---
 rtl/proc_pkg.sv | 24 ++
 rtl/mem_array.sv | 44 ++++
 rtl/mem_responder.sv | 111 +++++++++++
 tb/tb_mem_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types and constants for the pipeline's memory-side responder.
// Optional feature macro used by this slice: MEM_BYTE_WRITE_EN (byte-enabled writes).
package proc_pkg;

  localparam int WORD_W    = 16;
  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_RESP = 2'd2
  } mem_state_t;

  // Replace only the byte lanes selected by be; be[1] covers the high byte.
  function automatic logic [WORD_W-1:0] merge_word(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] new_word,
    input logic [1:0]        be
  );
    merge_word = {be[1] ? new_word[15:8] : old_word[15:8],
                  be[0] ? new_word[7:0]  : old_word[7:0]};
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port 2**ADDR_W x 16 storage. One access per enabled edge; the
// registered read port returns the post-write word (write-first), so a
// write and its response word are formed on the same edge.
// Byte masking is always wired here; the top ties be to 2'b11 when
// MEM_BYTE_WRITE_EN is not defined.
module mem_array
  import proc_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [1:0]        be,
  output logic [WORD_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] storage [DEPTH];
  logic [WORD_W-1:0] next_word;

  assign next_word = we ? merge_word(storage[addr], wdata, be) : storage[addr];

  // Storage update; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      storage[addr] <= next_word;
    end
  end

  // Read register holds the last accessed word until the next access.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (en) begin
      rd_data <= next_word;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one word request at a time, waits
// MEM_LATENCY cycles, performs the access, then holds the response until
// the initiator takes it.
// Optional feature macro: MEM_BYTE_WRITE_EN adds req_be and byte-masked writes.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The initiator must hold a request (and its fields) until it is
// taken; ready never depends combinationally on valid. resp_valid, resp_data
// and resp_we stay stable from the rise of resp_valid until the transfer.
module mem_responder
  import proc_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int MEM_LATENCY = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
`ifdef MEM_BYTE_WRITE_EN
  input  logic [1:0]        req_be,
`endif
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_data,
  output logic              resp_we,
  output mem_state_t        fsm_state
);

  mem_state_t           state;
  logic [LAT_CNT_W-1:0] cnt;
  logic                 lat_we;
  logic [ADDR_W-1:0]    lat_addr;
  logic [WORD_W-1:0]    lat_wdata;
  logic [1:0]           lat_be;
  logic [1:0]           be_in;
  logic                 access_en;
  logic                 unused_addr_bits;

`ifdef MEM_BYTE_WRITE_EN
  assign be_in = req_be;
`else
  assign be_in = 2'b11;
`endif

  // Byte address: bit 0 and everything above the word index are ignored.
  assign unused_addr_bits = ^{req_addr[WORD_W-1:ADDR_W+1], req_addr[0]};

  assign req_ready  = (state == MS_IDLE);
  assign resp_valid = (state == MS_RESP);
  assign resp_we    = lat_we;
  assign fsm_state  = state;

  // The response-forming edge; a synchronous reset on that edge cancels the write.
  assign access_en = (state == MS_BUSY) && (cnt == '0) && !reset;

  // Request FSM with latency countdown and request latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= MS_IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= 2'b11;
    end else begin
      case (state)
        MS_IDLE: begin
          if (req_valid && req_ready) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr[ADDR_W:1];
            lat_wdata <= req_wdata;
            lat_be    <= be_in;
            cnt       <= LAT_CNT_W'(MEM_LATENCY - 1);
            state     <= MS_BUSY;
          end
        end
        MS_BUSY: begin
          if (cnt == '0) begin
            state <= MS_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MS_RESP: begin
          if (resp_valid && resp_ready) begin
            state <= MS_IDLE;
          end
        end
        default: state <= MS_IDLE;
      endcase
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .en      (access_en),
    .we      (lat_we),
    .addr    (lat_addr),
    .wdata   (lat_wdata),
    .be      (lat_be),
    .rd_data (resp_data)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (ADDR_W=12, MEM_LATENCY=5).
// Define MEM_BYTE_WRITE_EN to also exercise byte-enabled writes.
module tb_mem_responder;
  import proc_pkg::*;

  localparam int ADDR_W = 12;
  localparam int LAT    = 5;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        resp_we;
  mem_state_t  fsm_state;

  int passed = 0;
  int total  = 0;

  mem_responder #(
    .ADDR_W      (ADDR_W),
    .MEM_LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef MEM_BYTE_WRITE_EN
    .req_be     (req_be),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_we    (resp_we),
    .fsm_state  (fsm_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Driver: one full transaction. Completes the handshake only if resp_ready is high.
  task automatic do_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [1:0] be, output logic [15:0] data, output logic rwe,
                        output int lat, output int ready_hi);
    int n;
    n = 0;
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; ready_hi = 0;
    while (!resp_valid && lat < 100) begin
      if (req_ready) ready_hi++;
      @(posedge clk); #1; lat++;
    end
    data = resp_data;
    rwe  = resp_we;
    if (resp_ready) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [15:0] d;
    logic        w;
    int          lat, rh, n, hi_cnt, bad_cnt, a0, a1;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = 2'b11; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("reset_resp_valid", 32'(resp_valid), 32'h0);
    check("reset_resp_data",  32'(resp_data),  32'h0);
    check("reset_resp_we",    32'(resp_we),    32'h0);
    check("reset_req_ready",  32'(req_ready),  32'h1);
    check("reset_state",      32'(fsm_state),  32'(MS_IDLE));

    // Preload word at 0x000C and read it back
    do_txn(1'b1, 16'h000C, 16'h1234, 2'b11, d, w, lat, rh);
    check("preload_data", 32'(d), 32'h1234);
    do_txn(1'b0, 16'h000C, 16'h0000, 2'b11, d, w, lat, rh);
    check("read_latency",      32'(lat), 32'(LAT));
    check("read_ready_low",    32'(rh),  32'h0);
    check("read_data",         32'(d),   32'h1234);
    check("read_we",           32'(w),   32'h0);
    check("read_ready_after",  32'(req_ready),  32'h1);
    check("read_valid_after",  32'(resp_valid), 32'h0);

    // Write then read the same word
    do_txn(1'b1, 16'h0020, 16'hBEEF, 2'b11, d, w, lat, rh);
    check("write_data",    32'(d),   32'hBEEF);
    check("write_we",      32'(w),   32'h1);
    check("write_latency", 32'(lat), 32'(LAT));
    do_txn(1'b0, 16'h0020, 16'h0000, 2'b11, d, w, lat, rh);
    check("write_readback", 32'(d), 32'hBEEF);

    // Backpressure: response held 3 cycles while a new request is ignored
    resp_ready = 1'b0;
    do_txn(1'b0, 16'h0020, 16'h0000, 2'b11, d, w, lat, rh);
    check("bp_latency", 32'(lat), 32'(LAT));
    req_we = 1'b1; req_addr = 16'h0020; req_wdata = 16'h0000; req_valid = 1'b1;
    bad_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid !== 1'b1 || resp_data !== 16'hBEEF || resp_we !== 1'b0 || req_ready !== 1'b0)
        bad_cnt++;
      @(posedge clk); #1;
    end
    check("bp_stable_cycles", 32'(bad_cnt), 32'h0);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_valid_after_hs", 32'(resp_valid), 32'h0);
    check("bp_ready_after_hs", 32'(req_ready),  32'h1);
    do_txn(1'b0, 16'h0020, 16'h0000, 2'b11, d, w, lat, rh);
    check("bp_ignored_write", 32'(d), 32'hBEEF);

    // Reset 2 cycles into a write: no response, old value kept
    do_txn(1'b1, 16'h0040, 16'h5555, 2'b11, d, w, lat, rh);
    req_we = 1'b1; req_addr = 16'h0040; req_wdata = 16'hAAAA; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_state_busy", 32'(fsm_state), 32'(MS_BUSY));
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid) hi_cnt++;
      @(posedge clk); #1;
    end
    check("abort_no_resp", 32'(hi_cnt), 32'h0);
    do_txn(1'b0, 16'h0040, 16'h0000, 2'b11, d, w, lat, rh);
    check("abort_old_value", 32'(d), 32'h5555);

    // Address aliasing and ignored bit 0
    do_txn(1'b1, 16'h2002, 16'h1111, 2'b11, d, w, lat, rh);
    do_txn(1'b0, 16'h0002, 16'h0000, 2'b11, d, w, lat, rh);
    check("alias_read", 32'(d), 32'h1111);
    do_txn(1'b0, 16'h0003, 16'h0000, 2'b11, d, w, lat, rh);
    check("odd_addr_read", 32'(d), 32'h1111);

    // Back-to-back throughput with req_valid and resp_ready held high
    req_we = 1'b0; req_addr = 16'h000C; req_valid = 1'b1;
    a0 = -1; a1 = -1;
    for (int c = 0; c < 20; c++) begin
      if (req_ready) begin
        if (a0 < 0) a0 = c;
        else if (a1 < 0) a1 = c;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("b2b_spacing", 32'(a1 - a0), 32'(LAT + 2));
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("b2b_drain_ready", 32'(req_ready), 32'h1);

`ifdef MEM_BYTE_WRITE_EN
    // Byte-enabled writes
    do_txn(1'b1, 16'h0050, 16'h1234, 2'b11, d, w, lat, rh);
    do_txn(1'b1, 16'h0050, 16'hABCD, 2'b10, d, w, lat, rh);
    check("be10_resp", 32'(d), 32'hAB34);
    do_txn(1'b1, 16'h0050, 16'h1234, 2'b11, d, w, lat, rh);
    do_txn(1'b1, 16'h0050, 16'hABCD, 2'b00, d, w, lat, rh);
    check("be00_resp", 32'(d), 32'h1234);
    check("be00_we",   32'(w), 32'h1);
    do_txn(1'b0, 16'h0050, 16'h0000, 2'b11, d, w, lat, rh);
    check("be00_readback", 32'(d), 32'h1234);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
